// File: rtl/sr_input_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_input_debouncer_pkg
// Brief    : Shared channel state encoding and default timing constants.
// Revision : 1.0 - initial release
// ============================================================================
package sr_input_debouncer_pkg;

   typedef enum logic [1:0] {
      CH_LOW       = 2'd0,
      CH_RISE_WAIT = 2'd1,
      CH_HIGH      = 2'd2,
      CH_FALL_WAIT = 2'd3
   } chan_state_e;

   localparam logic [1:0] c_ST_LOW       = CH_LOW;
   localparam logic [1:0] c_ST_RISE_WAIT = CH_RISE_WAIT;
   localparam logic [1:0] c_ST_HIGH      = CH_HIGH;
   localparam logic [1:0] c_ST_FALL_WAIT = CH_FALL_WAIT;

   localparam int unsigned c_DEF_DEBOUNCE_CYCLES = 16;
   localparam int unsigned c_DEF_SYNC_STAGES     = 2;

   // Accepted level is 1 in HIGH and FALL_WAIT: the MSB of the encoding.
   function automatic logic stable_of(input logic [1:0] state);
      return (state == c_ST_HIGH) || (state == c_ST_FALL_WAIT);
   endfunction

endpackage : sr_input_debouncer_pkg
`default_nettype wire

// File: rtl/sr_input_debouncer_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Brief    : Synchronizer plus 4-state qualify FSM for one bouncy raw input.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
   import sr_input_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
   parameter int unsigned SYNC_STAGES     = c_DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable
);

   localparam int unsigned          c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0]   c_CNT_ZERO = '0;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_synced;
   logic [1:0]             r_state;
   logic [1:0]             w_state_nxt;
   logic [c_CNT_W-1:0]     r_cnt;
   logic [c_CNT_W-1:0]     w_cnt_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      end
   end

   assign w_synced = r_sync[SYNC_STAGES-1];

   // Counter only advances while below the limit, so it can never wrap.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_ST_LOW: begin
            if (w_synced) begin
               w_state_nxt = c_ST_RISE_WAIT;
               w_cnt_nxt   = c_CNT_ONE;
            end
         end
         c_ST_RISE_WAIT: begin
            if (!w_synced) begin
               w_state_nxt = c_ST_LOW;
               w_cnt_nxt   = c_CNT_ZERO;
            end else if (r_cnt == c_CNT_MAX) begin
               w_state_nxt = c_ST_HIGH;
               w_cnt_nxt   = c_CNT_ZERO;
            end else begin
               w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
         end
         c_ST_HIGH: begin
            if (!w_synced) begin
               w_state_nxt = c_ST_FALL_WAIT;
               w_cnt_nxt   = c_CNT_ONE;
            end
         end
         c_ST_FALL_WAIT: begin
            if (w_synced) begin
               w_state_nxt = c_ST_HIGH;
               w_cnt_nxt   = c_CNT_ZERO;
            end else if (r_cnt == c_CNT_MAX) begin
               w_state_nxt = c_ST_LOW;
               w_cnt_nxt   = c_CNT_ZERO;
            end else begin
               w_cnt_nxt   = r_cnt + c_CNT_ONE;
            end
         end
         default: begin
            w_state_nxt = c_ST_LOW;
            w_cnt_nxt   = c_CNT_ZERO;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_LOW;
         r_cnt   <= c_CNT_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign stable = stable_of(r_state);

endmodule : debounce_channel
`default_nettype wire

// File: rtl/sr_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : sr_input_debouncer
// Brief    : Debounces set/clear requests and drives clean J/K, pulses, conflict.
// Revision : 1.0 - initial release
// ============================================================================
module sr_input_debouncer
   import sr_input_debouncer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
   parameter int unsigned SYNC_STAGES     = c_DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_raw,
   input  logic clr_raw,
   output logic j,
   output logic k,
   output logic set_pulse,
   output logic clr_pulse,
   output logic conflict
);

   logic w_set_stable;
   logic w_clr_stable;
   logic w_j_nxt;
   logic w_k_nxt;

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_set_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (set_raw),
      .stable (w_set_stable)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .SYNC_STAGES     (SYNC_STAGES)
   ) u_clr_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (clr_raw),
      .stable (w_clr_stable)
   );

   // Both requests active means hold: neither J nor K is asserted.
   assign w_j_nxt = w_set_stable & ~w_clr_stable;
   assign w_k_nxt = w_clr_stable & ~w_set_stable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         j         <= 1'b0;
         k         <= 1'b0;
         set_pulse <= 1'b0;
         clr_pulse <= 1'b0;
         conflict  <= 1'b0;
      end else begin
         j         <= w_j_nxt;
         k         <= w_k_nxt;
         set_pulse <= w_j_nxt & ~j;
         clr_pulse <= w_k_nxt & ~k;
         conflict  <= w_set_stable & w_clr_stable;
      end
   end

endmodule : sr_input_debouncer
`default_nettype wire
